// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end.
//   word_t        : 32-bit machine word
//   HALT          : opcode field value that stops instruction fetch
//   fetch_state_t : fetch-stage FSM encoding
//   ifid_t        : IF/ID pipeline payload {valid, instr, pc, npc}
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT = 6'b111111;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

  // A bubble is all-zero so that decode sees a NOP and a zero npc.
  localparam ifid_t IFID_BUBBLE = '0;

endpackage

// File: rtl/ifid_latch.sv
// Generic pipeline latch holding one ifid_t payload.
// Priority: rst > flush (bubble) > stall (hold) > load (capture d) > bubble.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   flush    : load a bubble, overrides stall
//   stall    : hold current contents
//   load     : capture d this cycle; without it a bubble is inserted
//   d        : payload to capture
//   q        : registered payload
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  logic  load,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q <= IFID_BUBBLE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the icache request, a one-entry
// skid buffer for instructions returned while decode is stalled, and the
// IF/ID pipeline register.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | issuing requests at pc (unless stall_PC / redirect)
// BUFFERED | one accepted instruction parked in buf_q, no new requests
// HALTED   | HALT fetched, pc frozen, waiting for a redirect
//
// Ports:
//   CLK, RST           : clock, asynchronous active-high reset
//   stall_PC           : hold pc, suppress new requests
//   stall_IFID         : hold IF/ID
//   flush_IFID         : bubble into IF/ID (wins over stall_IFID)
//   redirect_valid/pc  : resolved control transfer from EX/MEM
//   ihit, iload        : icache response
//   iREN, iaddr        : icache request
//   ifid_*             : IF/ID payload for decode and hazard logic
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t      PC_INIT = 32'h0000_0000,
  parameter logic [5:0] HALT_OP = HALT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_PC,
  input  logic        stall_IFID,
  input  logic        flush_IFID,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc
);

  fetch_state_t state, next_state;
  word_t        pc, pc_next;
  ifid_t        buf_q, buf_next;
  logic         buf_halt, buf_halt_next;

  ifid_t        fetched;
  ifid_t        latch_d;
  ifid_t        ifid_q;
  logic         latch_load;
  logic         accept;
  logic         is_halt;

  // RST gates the request so iREN is low for the whole reset window.
  assign iREN    = !RST && (state == FETCH) && !stall_PC && !redirect_valid;
  assign iaddr   = pc;
  assign accept  = iREN && ihit;
  assign is_halt = (iload[31:26] == HALT_OP);

  always_comb begin
    fetched       = IFID_BUBBLE;
    fetched.valid = 1'b1;
    fetched.instr = iload;
    fetched.pc    = pc;
    fetched.npc   = pc + 32'd4;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= PC_INIT;
      buf_q    <= IFID_BUBBLE;
      buf_halt <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_next;
      buf_q    <= buf_next;
      buf_halt <= buf_halt_next;
    end
  end

  always_comb begin
    next_state    = state;
    pc_next       = pc;
    buf_next      = buf_q;
    buf_halt_next = buf_halt;
    latch_load    = 1'b0;
    latch_d       = fetched;

    if (redirect_valid) begin
      next_state    = FETCH;
      pc_next       = redirect_pc;
      buf_next      = IFID_BUBBLE;
      buf_halt_next = 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          latch_load = accept;
          if (accept) begin
            pc_next = pc + 32'd4;
            if (stall_IFID && !flush_IFID) begin
              next_state    = BUFFERED;
              buf_next      = fetched;
              buf_halt_next = is_halt;
            end else if (is_halt && !flush_IFID) begin
              next_state = HALTED;
            end
          end
        end
        BUFFERED: begin
          latch_d = buf_q;
          if (flush_IFID) begin
            // pc is not rewound; the accompanying redirect supplies it
            next_state    = FETCH;
            buf_next      = IFID_BUBBLE;
            buf_halt_next = 1'b0;
          end else if (!stall_IFID) begin
            latch_load    = 1'b1;
            // a buffered HALT stops fetching only once it reaches IF/ID
            next_state    = buf_halt ? HALTED : FETCH;
            buf_next      = IFID_BUBBLE;
            buf_halt_next = 1'b0;
          end
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

  ifid_latch u_ifid_latch (
    .clk   (CLK),
    .rst   (RST),
    .flush (flush_IFID || redirect_valid),
    .stall (stall_IFID),
    .load  (latch_load),
    .d     (latch_d),
    .q     (ifid_q)
  );

  assign ifid_valid = ifid_q.valid;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_npc   = ifid_q.npc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_PC, stall_IFID, flush_IFID, redirect_valid, ihit;
  logic [31:0] redirect_pc, iload;
  logic        iREN, ifid_valid;
  logic [31:0] iaddr, ifid_instr, ifid_pc, ifid_npc;

  localparam logic [31:0] HALT_ADDR  = 32'h0000_0040;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Icache model: a non-HALT word that encodes its own address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return {6'b000001, a[25:0]};
  endfunction

  assign iload = (iaddr == HALT_ADDR) ? HALT_INSTR : w(iaddr);

  fetch_stage dut (
    .CLK            (CLK),
    .RST            (RST),
    .stall_PC       (stall_PC),
    .stall_IFID     (stall_IFID),
    .flush_IFID     (flush_IFID),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ihit           (ihit),
    .iload          (iload),
    .iREN           (iREN),
    .iaddr          (iaddr),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_npc       (ifid_npc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic spc, input logic sif, input logic fl,
                       input logic rv, input logic [31:0] rpc, input logic hit);
    stall_PC       = spc;
    stall_IFID     = sif;
    flush_IFID     = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    ihit           = hit;
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        spc, sif, fl, hit;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_npc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // zero-wait fetch, stall_PC bubbles, flush-over-stall
    vecs[0] = '{0,0,0,1, 1, 32'h00, 1, w(32'h00), 32'h00, 32'h04};
    vecs[1] = '{0,0,0,1, 1, 32'h04, 1, w(32'h04), 32'h04, 32'h08};
    vecs[2] = '{0,0,0,1, 1, 32'h08, 1, w(32'h08), 32'h08, 32'h0C};
    vecs[3] = '{1,0,0,1, 0, 32'h0C, 0, 32'h0,     32'h0,  32'h0};
    vecs[4] = '{1,0,0,1, 0, 32'h0C, 0, 32'h0,     32'h0,  32'h0};
    vecs[5] = '{0,1,1,0, 1, 32'h0C, 0, 32'h0,     32'h0,  32'h0};
    vecs[6] = '{0,0,0,1, 1, 32'h0C, 1, w(32'h0C), 32'h0C, 32'h10};

    RST = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0);
    #2;
    chk("rst_iren",  {31'b0, iREN},       32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_iaddr", iaddr,               32'h0);
    chk("rst_instr", ifid_instr,          32'h0);
    chk("rst_npc",   ifid_npc,            32'h0);
    @(negedge CLK);
    RST = 1'b0;
    edge1();

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].spc, vecs[i].sif, vecs[i].fl, 0, 32'h0, vecs[i].hit);
      #1;
      chk($sformatf("v%0d_iren", i),  {31'b0, iREN}, {31'b0, vecs[i].e_iren});
      chk($sformatf("v%0d_iaddr", i), iaddr,         vecs[i].e_iaddr);
      edge1();
      chk($sformatf("v%0d_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
      chk($sformatf("v%0d_pc", i),    ifid_pc,    vecs[i].e_pc);
      chk($sformatf("v%0d_npc", i),   ifid_npc,   vecs[i].e_npc);
    end

    // stall buffering: accept at 0x10 while decode is stalled
    drive(0, 1, 0, 0, 32'h0, 1);
    #1;
    chk("buf_acc_iren",  {31'b0, iREN}, 32'h1);
    chk("buf_acc_iaddr", iaddr,         32'h10);
    edge1();
    chk("buf_hold_pc0", ifid_pc, 32'h0C);
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 32'h0, 1);
      #1;
      chk($sformatf("buf_stall%0d_iren", k), {31'b0, iREN}, 32'h0);
      edge1();
      chk($sformatf("buf_stall%0d_pc", k), ifid_pc,    32'h0C);
      chk($sformatf("buf_stall%0d_in", k), ifid_instr, w(32'h0C));
    end
    drive(0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("buf_rel_iren", {31'b0, iREN}, 32'h0);
    edge1();
    chk("buf_out_valid", {31'b0, ifid_valid}, 32'h1);
    chk("buf_out_instr", ifid_instr, w(32'h10));
    chk("buf_out_pc",    ifid_pc,    32'h10);
    chk("buf_out_npc",   ifid_npc,   32'h14);
    chk("buf_resume",    iaddr,      32'h14);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 32'h0, 1);
      #1;
      chk($sformatf("seq%0d_iaddr", k), iaddr, 32'h14 + 32'(4 * k));
      edge1();
      chk($sformatf("seq%0d_pc", k), ifid_pc, 32'h14 + 32'(4 * k));
    end

    // redirect while a request is pending, with a same-cycle hit
    drive(0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("rd_pend_iren",  {31'b0, iREN}, 32'h1);
    chk("rd_pend_iaddr", iaddr,         32'h20);
    edge1();
    drive(0, 0, 0, 1, 32'h100, 1);
    #1;
    chk("rd_iren", {31'b0, iREN}, 32'h0);
    edge1();
    chk("rd_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rd_instr", ifid_instr, 32'h0);
    chk("rd_npc",   ifid_npc,   32'h0);
    chk("rd_iaddr", iaddr,      32'h100);

    // HALT at 0x40, then redirect to 0x80
    drive(0, 0, 0, 1, HALT_ADDR, 0);
    edge1();
    drive(0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("halt_iaddr", iaddr, HALT_ADDR);
    edge1();
    chk("halt_instr", ifid_instr, HALT_INSTR);
    chk("halt_pc",    ifid_pc,    HALT_ADDR);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("halt_iren%0d", k), {31'b0, iREN}, 32'h0);
      edge1();
    end
    chk("halt_pc_frozen", iaddr, 32'h44);
    chk("halt_bubble", {31'b0, ifid_valid}, 32'h0);
    drive(0, 0, 0, 1, 32'h80, 0);
    edge1();
    drive(0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("unhalt_iren",  {31'b0, iREN}, 32'h1);
    chk("unhalt_iaddr", iaddr,         32'h80);
    edge1();
    chk("unhalt_pc", ifid_pc, 32'h80);

    // pc wrap at the top of the address space
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    edge1();
    drive(0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("wrap_iaddr0", iaddr, 32'hFFFF_FFFC);
    edge1();
    chk("wrap_pc",     ifid_pc,  32'hFFFF_FFFC);
    chk("wrap_npc",    ifid_npc, 32'h0);
    chk("wrap_iaddr1", iaddr,    32'h0);

    // async reset between edges while BUFFERED
    drive(0, 1, 0, 0, 32'h0, 1);
    edge1();
    #1;
    chk("ar_buffered", {31'b0, iREN}, 32'h0);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_iaddr", iaddr,               32'h0);
    chk("ar_iren",  {31'b0, iREN},       32'h0);
    chk("ar_valid", {31'b0, ifid_valid}, 32'h0);
    chk("ar_pc",    ifid_pc,             32'h0);
    drive(0, 0, 0, 0, 32'h0, 0);
    @(negedge CLK);
    RST = 1'b0;
    edge1();
    drive(0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("post_iren",  {31'b0, iREN}, 32'h1);
    chk("post_iaddr", iaddr,         32'h0);
    edge1();
    chk("post_valid", {31'b0, ifid_valid}, 32'h1);
    chk("post_pc",    ifid_pc,             32'h0);
    chk("post_iaddr2", iaddr,              32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the 5-stage pipeline. Holds the PC and drives icache requests.
- Buffers one returned instruction when decode is stalled, and owns the IF/ID pipeline register.
- Consumes stall_PC, stall_IFID and flush_IFID from the hazard logic, plus the resolved branch/jump target from EX/MEM.
- Produces the IF/ID payload read by decode and by hazard detection.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that stops further fetching.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- stall_PC  in  1  hold PC and suppress new fetch
- stall_IFID  in  1  hold IF/ID register contents
- flush_IFID  in  1  load a bubble into IF/ID
- redirect_valid  in  1  EX/MEM resolved a taken/mispredicted control transfer
- redirect_pc  in  32  target PC for redirect
- ihit  in  1  icache returns data this cycle
- iload  in  32  instruction word, valid when ihit
- iREN  out  1  icache read request
- iaddr  out  32  icache address (= PC)
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  IF/ID instruction (0 for a bubble)
- ifid_pc  out  32  PC of IF/ID instruction
- ifid_npc  out  32  PC+4 of IF/ID instruction (0 for a bubble)

Behaviour:
- Reset (async, while RST=1):
  - pc=PC_INIT, state=FETCH, buffer empty.
  - ifid_valid=0; ifid_instr=0, ifid_pc=0, ifid_npc=0.
  - Combinational outputs resolve to iREN=0 during reset.
- States: FETCH, BUFFERED, HALTED.
- Request rules:
  - iREN=1 only in FETCH with stall_PC=0 and redirect_valid=0. iaddr=pc always.
  - Request held with a stable address until ihit. ihit in the same cycle as iREN (zero-wait) is legal.
- Accept = iREN & ihit. Each accept advances pc <= pc+4, mod 2^32, wrap from FFFF_FFFC to 0000_0000.
- Redirect has the highest priority:
  - pc <= redirect_pc, state <= FETCH.
  - Buffer and IF/ID are invalidated in the same cycle, regardless of stall_PC/stall_IFID.
  - Any ihit in that cycle is discarded.
- IF/ID update, in priority order:
  1. RST
  2. flush_IFID or redirect_valid -> bubble
  3. stall_IFID -> hold
  4. BUFFERED -> load buffer, state <= FETCH
  5. accept -> load {iload, pc, pc+4}, ifid_valid=1
  6. otherwise -> bubble
- Buffering: accept while stall_IFID=1 (and no flush) -> capture {iload, pc, pc+4} into the buffer, state <= BUFFERED.
  - No fetch is issued while BUFFERED.
  - Exactly one stall cycle, or many, lose no instruction and duplicate none.
- Flush while BUFFERED: buffer is discarded, state <= FETCH. pc is not rewound; redirect supplies the new PC.
- Halt: accept with iload[31:26]==HALT_OP -> HALT enters IF/ID (or the buffer) normally, state <= HALTED.
  - In HALTED: iREN=0, pc frozen.
  - A later redirect returns to FETCH, cancelling a speculatively fetched HALT.
- Latency: accept at cycle N -> visible on ifid_* at N+1, absent stalls.
- stall_PC=1 with stall_IFID=0: IF/ID receives a bubble each cycle; pc unchanged.

Decomposition:
- Shared package cpu_types_pkg, holding:
  - word_t
  - opcode field constant HALT
  - fetch_state_t enum {FETCH, BUFFERED, HALTED}
  - packed ifid_t {valid, instr, pc, npc}
- Sub-module ifid_latch: the IF/ID register with flush-over-stall priority and bubble insertion. Reusable pattern for the other pipeline latches.
- fetch_stage contains the PC, FSM, buffer and request logic.

Test Plan:
- Reset with zero-wait icache:
  - After RST release, iaddr=0, 4, 8 on consecutive cycles.
  - ifid_pc lags by one cycle; ifid_npc = ifid_pc+4.
- Stall buffering:
  - Accept at pc=0x10 while stall_IFID=1 for 3 cycles.
  - iREN=0 during the stall; IF/ID holds its prior value.
  - On release, IF/ID = {instr@0x10, 0x10, 0x14}, then fetch resumes at 0x14.
- Redirect during wait:
  - Request at pc=0x20 pending, redirect_valid=1, redirect_pc=0x100, ihit=1 in the same cycle.
  - Data is dropped; IF/ID is a bubble (instr=0, npc=0); next iaddr=0x100.
- HALT:
  - Fetch HALT at 0x40 -> IF/ID shows it, then iREN stays 0 for 10 cycles.
  - Redirect to 0x80 -> fetch resumes at 0x80.
- stall_PC=1 alone for 2 cycles:
  - iaddr steady; two bubbles enter IF/ID.
  - flush_IFID with stall_IFID both set -> bubble (flush wins).
- Async reset mid-operation:
  - Assert RST between clock edges while BUFFERED.
  - Outputs clear immediately and pc=PC_INIT.
